// File: rtl/booth_mult_sequencer.sv
// Issue/collect stage for a sequential Booth multiplier: buffers operand pairs,
// launches one multiply at a time and holds the product until the consumer takes it.
module booth_mult_sequencer #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_mc,
    input  logic [WIDTH-1:0]                in_mp,
    output logic [WIDTH-1:0]                mul_mc,
    output logic [WIDTH-1:0]                mul_mp,
    output logic                            mul_start,
    input  logic                            mul_busy,
    input  logic [2*WIDTH-1:0]              mul_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2*WIDTH-1:0]              out_product,
    output logic                            err,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_ARM     = 3'd2,
        ST_RUN     = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    logic [WIDTH-1:0]   mc_mem_r [FIFO_DEPTH];
    logic [WIDTH-1:0]   mp_mem_r [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [LW-1:0]      level_r;
    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   mul_mc_r;
    logic [WIDTH-1:0]   mul_mp_r;
    logic               mul_start_r;
    logic               out_valid_r;
    logic [2*WIDTH-1:0] out_product_r;
    logic               err_r;

    logic               in_ready_s;
    logic               push_s;
    logic               pop_s;

    // Full refuses pushes even when a pop happens in the same cycle.
    assign in_ready_s = (level_r != LW'(FIFO_DEPTH));
    assign push_s     = in_valid && in_ready_s;
    assign pop_s      = (state_r == ST_IDLE) && (level_r != '0) && !out_valid_r;

    assign in_ready    = in_ready_s;
    assign fifo_level  = level_r;
    assign mul_mc      = mul_mc_r;
    assign mul_mp      = mul_mp_r;
    assign mul_start   = mul_start_r;
    assign out_valid   = out_valid_r;
    assign out_product = out_product_r;
    assign err         = err_r;

    // Operand storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mc_mem_r[wr_ptr_r] <= in_mc;
            mp_mem_r[wr_ptr_r] <= in_mp;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Issue/collect sequencer with registered multiplier and consumer outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            mul_mc_r      <= '0;
            mul_mp_r      <= '0;
            mul_start_r   <= 1'b0;
            out_valid_r   <= 1'b0;
            out_product_r <= '0;
            err_r         <= 1'b0;
        end else begin
            if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        mul_mc_r    <= mc_mem_r[rd_ptr_r];
                        mul_mp_r    <= mp_mem_r[rd_ptr_r];
                        mul_start_r <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mul_start_r <= 1'b0;
                    cnt_r       <= '0;
                    state_r     <= ST_ARM;
                end
                ST_ARM: begin
                    if (mul_busy) begin
                        cnt_r   <= '0;
                        state_r <= ST_RUN;
                    end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                        err_r   <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (!mul_busy) begin
                        state_r <= ST_CAPTURE;
                    end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                        err_r   <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_CAPTURE: begin
                    out_product_r <= mul_out;
                    out_valid_r   <= 1'b1;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    mul_start_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Directed bench for booth_mult_sequencer with a behavioural 8-cycle multiplier stand-in.
module tb_booth_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_mc;
    logic [7:0]  in_mp;
    logic [7:0]  mul_mc;
    logic [7:0]  mul_mp;
    logic        mul_start;
    logic        mul_busy;
    logic [15:0] mul_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic        err;
    logic [2:0]  fifo_level;

    int          total = 0;
    int          bad   = 0;
    int          starts = 0;
    int          base;
    logic        hang = 1'b0;
    logic [3:0]  bcnt;
    logic [15:0] got_q[$];
    logic        acc [6];

    booth_mult_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mc(in_mc), .in_mp(in_mp),
        .mul_mc(mul_mc), .mul_mp(mul_mp), .mul_start(mul_start),
        .mul_busy(mul_busy), .mul_out(mul_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .err(err), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: busy for 8 cycles after start, product valid as busy falls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_busy <= 1'b0;
            bcnt     <= 4'd0;
            mul_out  <= 16'd0;
        end else if (mul_start && !hang) begin
            mul_busy <= 1'b1;
            bcnt     <= 4'd8;
        end else if (bcnt != 4'd0) begin
            bcnt <= bcnt - 4'd1;
            if (bcnt == 4'd1) begin
                mul_busy <= 1'b0;
                mul_out  <= $signed(mul_mc) * $signed(mul_mp);
            end
        end
    end

    // Collect accepted products and count start pulses.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back(out_product);
        if (rst_n && mul_start) starts++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] mc, input logic [7:0] mp);
        @(negedge clk);
        in_valid = 1'b1;
        in_mc    = mc;
        in_mp    = mp;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_prod(input int n);
        for (int i = 0; i < 300 && got_q.size() < n; i++) @(negedge clk);
        check_eq("prod_count", got_q.size(), n);
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 50 && !mul_busy; i++) @(negedge clk);
        check_eq("busy_seen", {31'd0, mul_busy}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_mc = 8'd0; in_mp = 8'd0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_level", fifo_level, 3'd0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_err", err, 1'b0);

        // 1: 5*4, start pulse two cycles after push
        got_q.delete(); base = starts;
        push(8'd5, 8'd4);
        @(negedge clk);
        check_eq("t1_start_latency", mul_start, 1'b1);
        wait_prod(1);
        if (got_q.size() > 0) check_eq("t1_prod", got_q[0], 16'd20);
        check_eq("t1_starts", starts - base, 1);

        // 2: -3*7, operands held during busy
        got_q.delete();
        push(8'hFD, 8'h07);
        wait_busy();
        repeat (3) @(negedge clk);
        check_eq("t2_mc_stable", mul_mc, 8'hFD);
        check_eq("t2_mp_stable", mul_mp, 8'h07);
        wait_prod(1);
        if (got_q.size() > 0) check_eq("t2_prod", got_q[0], 16'hFFEB);

        // 3: six back-to-back pairs with consumer stalled
        got_q.delete(); base = starts; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            case (i)
                0: begin in_mc = 8'd1;   in_mp = 8'd2;   end
                1: begin in_mc = 8'hFF;  in_mp = 8'hFF;  end
                2: begin in_mc = 8'h7F;  in_mp = 8'h80;  end
                3: begin in_mc = 8'h80;  in_mp = 8'h80;  end
                4: begin in_mc = 8'd10;  in_mp = 8'hF6;  end
                default: begin in_mc = 8'd3; in_mp = 8'd3; end
            endcase
            acc[i] = in_ready;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("t3_acc5", acc[4], 1'b1);
        check_eq("t3_refuse6", acc[5], 1'b0);
        repeat (30) @(negedge clk);
        check_eq("t3_held_valid", out_valid, 1'b1);
        check_eq("t3_level_full", fifo_level, 3'd4);
        check_eq("t3_in_ready_low", in_ready, 1'b0);
        check_eq("t3_one_start", starts - base, 1);
        check_eq("t3_none_taken", got_q.size(), 0);

        // 6: release consumer while offering a pair at full FIFO
        out_ready = 1'b1; in_valid = 1'b1; in_mc = 8'h55; in_mp = 8'h01;
        @(negedge clk);
        check_eq("t6_level_hold", fifo_level, 3'd4);
        check_eq("t6_ready_low", in_ready, 1'b0);
        @(negedge clk);
        check_eq("t6_level_pop", fifo_level, 3'd3);
        in_valid = 1'b0;
        wait_prod(5);
        repeat (40) @(negedge clk);
        check_eq("t3_total_prod", got_q.size(), 5);
        if (got_q.size() >= 5) begin
            check_eq("t3_p0", got_q[0], 16'h0002);
            check_eq("t3_p1", got_q[1], 16'h0001);
            check_eq("t3_p2", got_q[2], 16'hC080);
            check_eq("t3_p3", got_q[3], 16'h4000);
            check_eq("t3_p4", got_q[4], 16'hFF9C);
        end

        // 4: multiplier never goes busy
        got_q.delete(); hang = 1'b1;
        push(8'd2, 8'd3);
        repeat (20) @(negedge clk);
        check_eq("t4_err_early", err, 1'b0);
        for (int i = 0; i < 40 && !err; i++) @(negedge clk);
        check_eq("t4_err_set", err, 1'b1);
        check_eq("t4_dropped", got_q.size(), 0);
        hang = 1'b0;
        push(8'd6, 8'd7);
        wait_prod(1);
        if (got_q.size() > 0) check_eq("t4_next_prod", got_q[0], 16'h002A);
        check_eq("t4_err_sticky", err, 1'b1);

        // 5: reset during RUN
        got_q.delete();
        push(8'd9, 8'd9);
        wait_busy();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t5_mc", mul_mc, 8'd0);
        check_eq("t5_mp", mul_mp, 8'd0);
        check_eq("t5_start", mul_start, 1'b0);
        check_eq("t5_valid", out_valid, 1'b0);
        check_eq("t5_product", out_product, 16'd0);
        check_eq("t5_err", err, 1'b0);
        check_eq("t5_level", fifo_level, 3'd0);
        check_eq("t5_in_ready", in_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(8'd4, 8'hFE);
        wait_prod(1);
        if (got_q.size() > 0) check_eq("t5_prod", got_q[0], 16'hFFF8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
